// File: rtl/lcd_write_scheduler.sv
// Character-LCD write scheduler: byte FIFO from the IO decode, power-on init sequence,
// and E-strobe / settle timing so the CPU only pushes bytes and reads status.
module lcd_write_scheduler #(
  parameter int FIFO_DEPTH    = 8,
  parameter int POWERUP_CYC   = 750000,
  parameter int E_SETUP_CYC   = 2,
  parameter int E_PULSE_CYC   = 12,
  parameter int CMD_WAIT_CYC  = 2500,
  parameter int SLOW_WAIT_CYC = 82000
) (
  input  logic                               Clock,
  input  logic                               Reset_L,
  input  logic                               wr_en,
  input  logic                               wr_is_data,
  input  logic [7:0]                         wr_byte,
  output logic                               fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               busy,
  output logic                               init_done,
  output logic                               overflow,
  input  logic                               ovf_clr,
  output logic                               RS_pin,
  output logic                               RW_pin,
  output logic                               E_pin,
  output logic [7:0]                         LCD_DataOut
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam int MAX_A   = (POWERUP_CYC > SLOW_WAIT_CYC) ? POWERUP_CYC : SLOW_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > E_SETUP_CYC) ? MAX_C : E_SETUP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] ST_POWERUP = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_IDLE    = 3'd2;
  localparam logic [2:0] ST_SETUP   = 3'd3;
  localparam logic [2:0] ST_PULSE   = 3'd4;
  localparam logic [2:0] ST_WAIT    = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       init_idx;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          slow_cmd;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  // Fullness is judged on the pre-pop count, so a push while full is dropped even if a pop coincides.
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign push      = wr_en && !fifo_full;
  assign pop       = (state == ST_IDLE) && (fifo_count != '0);
  assign busy      = !((state == ST_IDLE) && (fifo_count == '0));
  assign RW_pin    = 1'b0;
  assign slow_cmd  = !RS_pin && ((LCD_DataOut == 8'h01) || (LCD_DataOut == 8'h02) ||
                                 (LCD_DataOut == 8'h03));

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= {wr_is_data, wr_byte};
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (ovf_clr)       overflow <= 1'b0;
    end
  end

  // Every state entry reloads cnt with (duration - 1); the state ends when cnt reaches zero.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state       <= ST_POWERUP;
      cnt         <= CNT_W'(POWERUP_CYC - 1);
      init_idx    <= 2'd0;
      init_done   <= 1'b0;
      E_pin       <= 1'b0;
      RS_pin      <= 1'b0;
      LCD_DataOut <= 8'h00;
    end else begin
      case (state)
        ST_POWERUP: begin
          if (cnt == '0) begin
            RS_pin      <= 1'b0;
            LCD_DataOut <= init_byte(2'd0);
            init_idx    <= 2'd0;
            cnt         <= CNT_W'(E_SETUP_CYC - 1);
            state       <= ST_SETUP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_INIT: begin
          RS_pin      <= 1'b0;
          LCD_DataOut <= init_byte(init_idx);
          cnt         <= CNT_W'(E_SETUP_CYC - 1);
          state       <= ST_SETUP;
        end
        ST_IDLE: begin
          if (pop) begin
            {RS_pin, LCD_DataOut} <= mem[rd_ptr];
            cnt   <= CNT_W'(E_SETUP_CYC - 1);
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            E_pin <= 1'b1;
            cnt   <= CNT_W'(E_PULSE_CYC - 1);
            state <= ST_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            E_pin <= 1'b0;
            cnt   <= slow_cmd ? CNT_W'(SLOW_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (init_done) begin
            state <= ST_IDLE;
          end else if (init_idx == 2'd3) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            init_idx <= init_idx + 2'd1;
            state    <= ST_INIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
